// File: rtl/onehot_finish_monitor.sv
// onehot_finish_monitor
// Registered one-hot finish detector: samples a WIDTH-bit status word under a
// start/valid handshake and declares completion once HOLD consecutive valid
// samples are one-hot on the same bit. Tracks the hot-bit index, sticky
// zero-hot / multi-hot error flags and a saturating count of accepted samples.
module onehot_finish_monitor #(
    parameter  int unsigned WIDTH = 4,
    parameter  int unsigned HOLD  = 1,
    localparam int unsigned IDX_W = $clog2(WIDTH),
    localparam int unsigned RUN_W = $clog2(HOLD + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             valid,
    input  logic [WIDTH-1:0] a,
    output logic             busy,
    output logic             is_finished,
    output logic [IDX_W-1:0] hot_idx,
    output logic             zero_err,
    output logic             multi_err,
    output logic [15:0]      sample_count
);

    typedef enum logic [1:0] {
        IDLE,
        CHECK,
        DONE
    } state_t;

    state_t             state, state_n;
    logic [RUN_W-1:0]   run, run_n;
    logic [IDX_W-1:0]   prev_idx, prev_idx_n;
    logic [IDX_W-1:0]   hot_idx_n;
    logic               zero_err_n, multi_err_n;
    logic [15:0]        sample_count_n;

    // Saturating set-bit count: 0 = zero-hot, 1 = one-hot, 2 = two or more.
    logic [1:0]         ones;
    logic [IDX_W-1:0]   cur_idx;
    logic               is_zero, is_onehot, is_multi;

    // Classify the status word; cur_idx is only meaningful when one-hot.
    always_comb begin
        ones    = '0;
        cur_idx = '0;
        for (int unsigned i = 0; i < WIDTH; i++) begin
            if (a[i]) begin
                cur_idx = IDX_W'(i);
                if (ones != 2'd2) begin
                    ones = ones + 2'd1;
                end
            end
        end
        is_zero   = (ones == 2'd0);
        is_onehot = (ones == 2'd1);
        is_multi  = (ones == 2'd2);
    end

    // Next-state and next-status computation; every register holds by default.
    always_comb begin
        state_n        = state;
        run_n          = run;
        prev_idx_n     = prev_idx;
        hot_idx_n      = hot_idx;
        zero_err_n     = zero_err;
        multi_err_n    = multi_err;
        sample_count_n = sample_count;

        case (state)
            IDLE, DONE: begin
                if (start) begin
                    state_n        = CHECK;
                    run_n          = '0;
                    prev_idx_n     = '0;
                    hot_idx_n      = '0;
                    zero_err_n     = 1'b0;
                    multi_err_n    = 1'b0;
                    sample_count_n = '0;
                end
            end
            CHECK: begin
                if (start) begin
                    // Restart: same-cycle sample is discarded.
                    run_n          = '0;
                    prev_idx_n     = '0;
                    hot_idx_n      = '0;
                    zero_err_n     = 1'b0;
                    multi_err_n    = 1'b0;
                    sample_count_n = '0;
                end else if (valid) begin
                    if (sample_count != '1) begin
                        sample_count_n = sample_count + 16'd1;
                    end
                    if (is_onehot) begin
                        if (run == '0 || cur_idx == prev_idx) begin
                            run_n = run + RUN_W'(1);
                        end else begin
                            run_n = RUN_W'(1);
                        end
                        prev_idx_n = cur_idx;
                        if (run_n == RUN_W'(HOLD)) begin
                            state_n   = DONE;
                            hot_idx_n = cur_idx;
                        end
                    end else if (is_zero) begin
                        run_n      = '0;
                        zero_err_n = 1'b1;
                    end else if (is_multi) begin
                        run_n       = '0;
                        multi_err_n = 1'b1;
                    end
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    // State and status registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            run          <= '0;
            prev_idx     <= '0;
            hot_idx      <= '0;
            zero_err     <= 1'b0;
            multi_err    <= 1'b0;
            sample_count <= '0;
        end else begin
            state        <= state_n;
            run          <= run_n;
            prev_idx     <= prev_idx_n;
            hot_idx      <= hot_idx_n;
            zero_err     <= zero_err_n;
            multi_err    <= multi_err_n;
            sample_count <= sample_count_n;
        end
    end

    assign busy        = (state == CHECK);
    assign is_finished = (state == DONE);

endmodule

// File: tb/tb_onehot_finish_monitor.sv
// Directed bench for onehot_finish_monitor: three configurations
// (W4/H1, W8/H3, W4/H2) checked against hand-computed expectations.
module tb_onehot_finish_monitor;

    logic clk;
    logic rst_n;

    // Instance A: WIDTH=4, HOLD=1
    logic        st_a, vl_a;
    logic [3:0]  a_a;
    logic        busy_a, fin_a, zerr_a, merr_a;
    logic [1:0]  idx_a;
    logic [15:0] cnt_a;

    // Instance B: WIDTH=8, HOLD=3
    logic        st_b, vl_b;
    logic [7:0]  a_b;
    logic        busy_b, fin_b, zerr_b, merr_b;
    logic [2:0]  idx_b;
    logic [15:0] cnt_b;

    // Instance C: WIDTH=4, HOLD=2
    logic        st_c, vl_c;
    logic [3:0]  a_c;
    logic        busy_c, fin_c, zerr_c, merr_c;
    logic [1:0]  idx_c;
    logic [15:0] cnt_c;

    int checks;
    int errors;

    onehot_finish_monitor #(.WIDTH(4), .HOLD(1)) u_a (
        .clk(clk), .rst_n(rst_n), .start(st_a), .valid(vl_a), .a(a_a),
        .busy(busy_a), .is_finished(fin_a), .hot_idx(idx_a),
        .zero_err(zerr_a), .multi_err(merr_a), .sample_count(cnt_a)
    );

    onehot_finish_monitor #(.WIDTH(8), .HOLD(3)) u_b (
        .clk(clk), .rst_n(rst_n), .start(st_b), .valid(vl_b), .a(a_b),
        .busy(busy_b), .is_finished(fin_b), .hot_idx(idx_b),
        .zero_err(zerr_b), .multi_err(merr_b), .sample_count(cnt_b)
    );

    onehot_finish_monitor #(.WIDTH(4), .HOLD(2)) u_c (
        .clk(clk), .rst_n(rst_n), .start(st_c), .valid(vl_c), .a(a_c),
        .busy(busy_c), .is_finished(fin_c), .hot_idx(idx_c),
        .zero_err(zerr_c), .multi_err(merr_c), .sample_count(cnt_c)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance one clock; outputs are observed 1 time unit after the edge.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst_n = 1'b0;
        st_a = 0; vl_a = 0; a_a = '0;
        st_b = 0; vl_b = 0; a_b = '0;
        st_c = 0; vl_c = 0; a_c = '0;
        #1;
        check("rst_busy",  32'(busy_a), 0);
        check("rst_fin",   32'(fin_a),  0);
        check("rst_idx",   32'(idx_a),  0);
        check("rst_zerr",  32'(zerr_a), 0);
        check("rst_merr",  32'(merr_a), 0);
        check("rst_cnt",   32'(cnt_a),  0);
        #10;
        rst_n = 1'b1;
        cyc();

        // W8/H3: 10,10,20,20,20 -> finish only after the 5th sample, idx 5
        st_b = 1; cyc(); st_b = 0;
        check("b_busy_start", 32'(busy_b), 1);
        begin
            logic [7:0] seq_b [5];
            logic       fin_exp [5];
            seq_b = '{8'h10, 8'h10, 8'h20, 8'h20, 8'h20};
            fin_exp = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
            for (int i = 0; i < 5; i++) begin
                vl_b = 1; a_b = seq_b[i]; cyc();
                check($sformatf("b_fin_%0d", i), 32'(fin_b), 32'(fin_exp[i]));
            end
            vl_b = 0;
        end
        check("b_idx",  32'(idx_b),  5);
        check("b_cnt",  32'(cnt_b),  5);
        check("b_busy", 32'(busy_b), 0);
        check("b_zerr", 32'(zerr_b), 0);
        check("b_merr", 32'(merr_b), 0);

        // W4/H2: 0000, 0011, 1000, 1000 -> both errors, finish after 4th, idx 3
        st_c = 1; cyc(); st_c = 0;
        vl_c = 1; a_c = 4'b0000; cyc();
        check("c_zerr_1", 32'(zerr_c), 1);
        check("c_merr_1", 32'(merr_c), 0);
        a_c = 4'b0011; cyc();
        check("c_merr_2", 32'(merr_c), 1);
        a_c = 4'b1000; cyc();
        check("c_fin_3", 32'(fin_c), 0);
        a_c = 4'b1000; cyc();
        vl_c = 0;
        check("c_fin_4",  32'(fin_c),  1);
        check("c_idx",    32'(idx_c),  3);
        check("c_zerr",   32'(zerr_c), 1);
        check("c_merr",   32'(merr_c), 1);
        check("c_cnt",    32'(cnt_c),  4);

        // W4/H1: single one-hot sample finishes next cycle
        st_a = 1; cyc(); st_a = 0;
        check("a_busy_start", 32'(busy_a), 1);
        check("a_fin_start",  32'(fin_a),  0);
        vl_a = 1; a_a = 4'b0100; cyc(); vl_a = 0;
        check("a_fin",  32'(fin_a),  1);
        check("a_idx",  32'(idx_a),  2);
        check("a_busy", 32'(busy_a), 0);
        check("a_cnt",  32'(cnt_a),  1);
        check("a_zerr", 32'(zerr_a), 0);
        check("a_merr", 32'(merr_a), 0);

        // Valid in DONE is ignored
        vl_a = 1; a_a = 4'b0001; cyc(); vl_a = 0;
        check("done_vl_fin", 32'(fin_a), 1);
        check("done_vl_idx", 32'(idx_a), 2);
        check("done_vl_cnt", 32'(cnt_a), 1);

        // Start in DONE: is_finished falls, status cleared
        st_a = 1; cyc(); st_a = 0;
        check("done_st_fin",  32'(fin_a),  0);
        check("done_st_busy", 32'(busy_a), 1);
        check("done_st_cnt",  32'(cnt_a),  0);
        check("done_st_idx",  32'(idx_a),  0);

        // Start with a one-hot valid sample in CHECK: discarded, counters cleared
        vl_a = 1; a_a = 4'b0000; cyc();
        check("chk_pre_cnt",  32'(cnt_a),  1);
        check("chk_pre_zerr", 32'(zerr_a), 1);
        st_a = 1; a_a = 4'b0001; cyc(); st_a = 0; vl_a = 0;
        check("chk_st_cnt",  32'(cnt_a),  0);
        check("chk_st_zerr", 32'(zerr_a), 0);
        check("chk_st_fin",  32'(fin_a),  0);
        check("chk_st_busy", 32'(busy_a), 1);

        // Asynchronous reset mid-CHECK with sample_count=5
        vl_a = 1; a_a = 4'b0000;
        repeat (5) cyc();
        vl_a = 0;
        check("mid_cnt", 32'(cnt_a), 5);
        rst_n = 1'b0;
        #1;
        check("async_busy", 32'(busy_a), 0);
        check("async_fin",  32'(fin_a),  0);
        check("async_idx",  32'(idx_a),  0);
        check("async_zerr", 32'(zerr_a), 0);
        check("async_merr", 32'(merr_a), 0);
        check("async_cnt",  32'(cnt_a),  0);
        check("async_fin_b", 32'(fin_b), 0);
        #1;
        rst_n = 1'b1;

        // After release, valid alone is ignored in IDLE
        vl_a = 1; a_a = 4'b0100; cyc();
        check("idle_vl_busy", 32'(busy_a), 0);
        check("idle_vl_fin",  32'(fin_a),  0);
        check("idle_vl_cnt",  32'(cnt_a),  0);

        // Start and valid together in IDLE: sample not counted
        st_a = 1; cyc(); st_a = 0;
        check("idle_st_cnt",  32'(cnt_a),  0);
        check("idle_st_busy", 32'(busy_a), 1);
        check("idle_st_fin",  32'(fin_a),  0);

        // Saturation: zero samples drive sample_count to FFFF and hold there
        a_a = 4'b0000;
        repeat (65535) cyc();
        check("sat_cnt_65535", 32'(cnt_a), 32'hFFFF);
        repeat (2) cyc();
        vl_a = 0;
        check("sat_cnt",  32'(cnt_a),  32'hFFFF);
        check("sat_zerr", 32'(zerr_a), 1);
        check("sat_merr", 32'(merr_a), 0);
        check("sat_busy", 32'(busy_a), 1);
        check("sat_fin",  32'(fin_a),  0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
